// File: rtl/div_share_arb.sv
// Round-robin arbiter sharing one combinational N/M divider among NREQ requesters.
// Optional build macro DIV_ZERO_CHK_EN: flag divide-by-zero and substitute a fixed result.
module div_share_arb #(
    parameter int N    = 32,
    parameter int M    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_dividend,
    input  logic [NREQ*M-1:0]    req_divisor,
    output logic [N-1:0]         div_dividend,
    output logic [M-1:0]         div_divisor,
    input  logic [N-1:0]         div_quotient,
    input  logic [M-1:0]         div_remainder,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [N-1:0]         rsp_quotient,
    output logic [M-1:0]         rsp_remainder,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] id_r;
    logic [N-1:0]   div_dividend_r;
    logic [M-1:0]   div_divisor_r;
    logic [N-1:0]   rsp_quotient_r;
    logic [M-1:0]   rsp_remainder_r;
    logic           rsp_err_r;

    logic [IDW-1:0] grant_s;
    logic           grant_vld_s;
    logic [N-1:0]   sel_dividend_s;
    logic [M-1:0]   sel_divisor_s;
    int             dist_s;
    int             best_dist_s;
    logic           take_s;

    // Pick the valid requester closest after ptr (distance 0 is ptr+1, wrapping)
    always_comb begin
        grant_s        = {IDW{1'b0}};
        sel_dividend_s = {N{1'b0}};
        sel_divisor_s  = {M{1'b0}};
        best_dist_s    = NREQ;
        dist_s         = 0;
        take_s         = 1'b0;
        grant_vld_s    = |req_valid;
        for (int i = 0; i < NREQ; i++) begin
            dist_s         = (i + 2 * NREQ - 1 - int'(ptr_r)) % NREQ;
            take_s         = req_valid[i] && (dist_s < best_dist_s);
            best_dist_s    = take_s ? dist_s : best_dist_s;
            grant_s        = take_s ? IDW'(i) : grant_s;
            sel_dividend_s = take_s ? req_dividend[i*N +: N] : sel_dividend_s;
            sel_divisor_s  = take_s ? req_divisor[i*M +: M] : sel_divisor_s;
        end
    end

    // One-hot accept, only while idle and out of reset
    always_comb begin
        req_ready = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state_r == S_IDLE) && rst_n && req_valid[i] && (grant_s == IDW'(i));
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  state_nxt_s = grant_vld_s ? S_CALC : S_IDLE;
            S_CALC:  state_nxt_s = S_RESP;
            S_RESP:  state_nxt_s = rsp_ready ? S_IDLE : S_RESP;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch on accept, result capture at the end of CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r           <= IDW'(NREQ - 1);
            id_r            <= {IDW{1'b0}};
            div_dividend_r  <= {N{1'b0}};
            div_divisor_r   <= {M{1'b0}};
            rsp_quotient_r  <= {N{1'b0}};
            rsp_remainder_r <= {M{1'b0}};
            rsp_err_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_vld_s) begin
                        div_dividend_r <= sel_dividend_s;
                        div_divisor_r  <= sel_divisor_s;
                        id_r           <= grant_s;
                        ptr_r          <= grant_s;
                    end
                end
                S_CALC: begin
`ifdef DIV_ZERO_CHK_EN
                    if (div_divisor_r == {M{1'b0}}) begin
                        rsp_quotient_r  <= {N{1'b1}};
                        rsp_remainder_r <= div_dividend_r[M-1:0];
                        rsp_err_r       <= 1'b1;
                    end else begin
                        rsp_quotient_r  <= div_quotient;
                        rsp_remainder_r <= div_remainder;
                        rsp_err_r       <= 1'b0;
                    end
`else
                    rsp_quotient_r  <= div_quotient;
                    rsp_remainder_r <= div_remainder;
                    rsp_err_r       <= 1'b0;
`endif
                end
                S_RESP: begin
                    rsp_err_r <= rsp_err_r;
                end
                default: begin
                    rsp_err_r <= 1'b0;
                end
            endcase
        end
    end

    assign div_dividend  = div_dividend_r;
    assign div_divisor   = div_divisor_r;
    assign rsp_id        = id_r;
    assign rsp_quotient  = rsp_quotient_r;
    assign rsp_remainder = rsp_remainder_r;
    assign rsp_err       = rsp_err_r;
    assign rsp_valid     = (state_r == S_RESP);
    assign busy          = (state_r != S_IDLE);

endmodule

// File: doc/div_share_arb.md
# div_share_arb

Round-robin arbiter and sequencer that shares one combinational N/M parallel divider among NREQ requesters. Each requester offers a dividend/divisor pair over a valid/ready handshake. The block latches the winning pair into registers that drive the divider, captures quotient and remainder one cycle later, and returns them on a single response channel tagged with the requester index. It sits between the requesting engines and the divider instance.

## Interface
- N, 32, dividend and quotient width (N >= M)
- M, 8, divisor and remainder width
- NREQ, 4, number of requesters (2..8)
- IDW, 2, response ID width (>= clog2(NREQ))
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock domain, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_dividend  in  NREQ*N  flattened; requester i in bits [i*N +: N]
- req_divisor  in  NREQ*M  flattened; requester i in bits [i*M +: M]
- div_dividend  out  N  registered operand to the divider
- div_divisor  out  M  registered operand to the divider
- div_quotient  in  N  divider result (combinational from div_* operands)
- div_remainder  in  M  divider result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester being answered
- rsp_quotient  out  N  captured quotient
- rsp_remainder  out  M  captured remainder
- rsp_err  out  1  divide-by-zero flag
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, CALC, RESP.
- IDLE:
  - grant = first requester with req_valid set, searching from (ptr+1) mod NREQ upward with wrap-around.
  - req_ready = onehot(grant), combinational.
  - If any req_valid: latch the granted operands into div_dividend/div_divisor, latch the ID, set ptr = grant, go to CALC.
- CALC: operands are held stable. At the end of the cycle, capture div_quotient/div_remainder into the rsp_* registers and go to RESP.
- RESP: rsp_valid=1. All outputs are held stable until rsp_valid&&rsp_ready, then go to IDLE.
- req_ready is 0 in CALC and RESP. Requests are never dropped. The requester holds req_valid and its operands until accepted.
- A requester that deasserts req_valid before it is accepted is simply not granted. There is no penalty.
- ptr resets to NREQ-1, so requester 0 has highest priority on the first arbitration. It does not advance when nothing is granted.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…

## Timing
- Accept in cycle 0 (req_valid&req_ready at edge).
- CALC is cycle 1.
- rsp_valid is high from cycle 2.
- Best-case throughput: one operation per 3 cycles (RESP handshake cycle, IDLE, CALC).
- Reset values:
  - req_ready=0 (state IDLE, but held 0 while rst_n low)
  - rsp_valid=0, rsp_err=0, busy=0
  - rsp_id=0, rsp_quotient=0, rsp_remainder=0
  - div_dividend=0, div_divisor=0
  - ptr=NREQ-1
- Reset asserted in any state: immediate return to IDLE. The in-flight operation is discarded and no response is issued.
- rsp_ready high while rsp_valid is low: ignored.

## Configuration
- DIV_ZERO_CHK_EN defined:
  - In CALC, if div_divisor==0, capture rsp_err=1, rsp_quotient={N{1'b1}}, rsp_remainder=div_dividend[M-1:0], ignoring the divider outputs.
  - Otherwise rsp_err=0.
- DIV_ZERO_CHK_EN undefined:
  - rsp_err tied 0.
  - Divider outputs are captured unchanged for every divisor, including 0.

## Test plan
- Single request: requester 2 offers 100/7 → req_ready[2] in cycle 0; rsp_valid in cycle 2 with rsp_id=2, q=14, r=2, err=0.
- Contention: all four valid every cycle with distinct operands, rsp_ready=1 → responses in ID order 0,1,2,3,0; each result is correct for its own requester's operands.
- Backpressure: rsp_ready low 5 cycles during RESP → rsp_* stable, busy=1, no req_ready; accept resumes the cycle after the handshake.
- Divide by zero with DIV_ZERO_CHK_EN: 0x00001234/0 → rsp_err=1, q=0xFFFFFFFF, r=0x34. Without the macro → err=0 and the raw divider output is passed through.
- Reset mid-CALC: rst_n low for one cycle → all outputs 0 immediately, no response for that request. The next request is accepted normally with requester 0 first.
